// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq_pkg: states, opcode classes, opcodes, ALU code and bus indices shared by branch_step_sequencer
package ctrl_seq_pkg;
   typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_t;
   typedef enum logic [1:0] {K_JR, K_JAL, K_BR, K_BAD} kind_t;
   localparam logic [4:0] OP_BR = 5'b10010;
   localparam logic [4:0] OP_JR = 5'b10011;
   localparam logic [4:0] OP_JAL = 5'b10100;
   localparam logic [5:0] ALU_ADD = 6'd3;
   localparam int ZLOW_IDX = 19;
   localparam int PC_IDX = 20;
   localparam int IR_IDX = 21;
   localparam int MDR_IDX = 22;
   localparam int MAR_IDX = 23;
   localparam int Y_IDX = 24;
   localparam int C_IDX = 25;
   function automatic kind_t decode(input logic [4:0] op);
      return op == OP_JR ? K_JR : op == OP_JAL ? K_JAL : op == OP_BR ? K_BR : K_BAD;
   endfunction
endpackage

// File: rtl/step_timer.sv
// step_timer: phase counter wrapping at DIV with last-phase flag; hold freezes it, zero forces phase 0
module step_timer #(
   parameter int DIV = 4,
   parameter int PW = $clog2(DIV)
) (
   input  logic          clock,
   input  logic          clr,
   input  logic          hold,
   input  logic          zero,
   output logic [PW-1:0] phase_n,
   output logic          last
);
   logic [PW-1:0] phase;
   assign last = phase == PW'(DIV - 1);
   assign phase_n = zero ? '0 : hold ? phase : last ? '0 : phase + 1'b1;
   always_ff @(posedge clock) phase <= clr ? '0 : phase_n;
endmodule

// File: rtl/branch_step_sequencer.sv
// branch_step_sequencer: T-step fetch/execute sequencer for jr, jal and br; SINGLE_STEP_EN adds step_req single-stepping
module branch_step_sequencer
   import ctrl_seq_pkg::*;
#(
   parameter int SEL_W = 32,
   parameter int STEP_DIV = 4,
   parameter int OPC_W = 5,
   parameter int ALU_W = 6
) (
   input  logic             clock,
   input  logic             clr,
`ifdef SINGLE_STEP_EN
   input  logic             step_req,
`endif
   input  logic             start,
   input  logic [31:0]      ir,
   input  logic             con_ff,
   output logic [SEL_W-1:0] enc_input,
   output logic [SEL_W-1:0] reg_enable,
   output logic [ALU_W-1:0] alu_sel,
   output logic             read,
   output logic             inc_pc,
   output logic             gra,
   output logic             grb,
   output logic             r_in,
   output logic             r_out,
   output logic             con_in,
   output logic             busy,
   output logic             done,
   output logic             illegal
);
   localparam int PW = $clog2(STEP_DIV);
   state_t state, ns;
   kind_t kind, kn;
   logic fin, fin_n, hold, zero, last, stall_n, step_end, enter3, cap, unused_ir;
   logic [PW-1:0] phase_n;
   logic [SEL_W-1:0] enc_n, en_n;
   logic [ALU_W-1:0] alu_n;
   logic read_n, inc_n, gra_n, grb_n, rin_n, rout_n, conin_n;
   assign unused_ir = ^ir[31-OPC_W:0];
`ifdef SINGLE_STEP_EN
   logic stall;
   assign stall_n = state != IDLE && (stall ? !step_req : last);
   assign step_end = stall && step_req;
   always_ff @(posedge clock) stall <= clr ? 1'b0 : stall_n;
`else
   assign stall_n = 1'b0;
   assign step_end = state != IDLE && last;
`endif
   assign hold = state == IDLE || stall_n;
   assign zero = ns == IDLE;
   step_timer #(.DIV(STEP_DIV), .PW(PW)) u_timer (
      .clock(clock), .clr(clr), .hold(hold), .zero(zero), .phase_n(phase_n), .last(last)
   );
   always_comb begin
      ns = state;
      if (state == IDLE) ns = start && !fin ? T0 : IDLE;
      else if (state == T3 && kind == K_BAD) ns = IDLE;
      else if (step_end) ns = state == T6 || (state == T4 && kind != K_BR) ? IDLE : state_t'(state + 3'd1);
   end
   assign enter3 = ns == T3 && state != T3;
   assign kn = enter3 ? decode(OPC_W'(ir[31 -: OPC_W])) : kind;
   assign fin_n = step_end && ns == IDLE;
   assign cap = phase_n == PW'(STEP_DIV - 1);
   always_comb begin
      enc_n = '0;
      en_n = '0;
      alu_n = '0;
      {read_n, inc_n, gra_n, grb_n, rin_n, rout_n, conin_n} = '0;
      if (!stall_n)
         case (ns)
            T0: begin enc_n[PC_IDX] = 1'b1; en_n[MAR_IDX] = cap; inc_n = cap; end
            T1: begin read_n = 1'b1; en_n[MDR_IDX] = cap; end
            T2: begin enc_n[MDR_IDX] = 1'b1; en_n[IR_IDX] = cap; end
            T3: if (kn == K_JAL) begin enc_n[PC_IDX] = 1'b1; grb_n = 1'b1; rin_n = cap; end
               else if (kn == K_BR) begin gra_n = 1'b1; rout_n = 1'b1; conin_n = cap; end
            T4: if (kn == K_BR) begin enc_n[PC_IDX] = 1'b1; en_n[Y_IDX] = cap; end
               else begin gra_n = 1'b1; rout_n = 1'b1; en_n[PC_IDX] = cap; end
            T5: begin enc_n[C_IDX] = 1'b1; alu_n = ALU_W'(ALU_ADD); en_n[ZLOW_IDX] = cap; end
            T6: begin enc_n[ZLOW_IDX] = 1'b1; en_n[PC_IDX] = cap && con_ff; end
            default: ;
         endcase
   end
   always_ff @(posedge clock)
      if (clr) begin
         state <= IDLE;
         kind <= K_JR;
         fin <= 1'b0;
         enc_input <= '0;
         reg_enable <= '0;
         alu_sel <= '0;
         {read, inc_pc, gra, grb, r_in, r_out, con_in, busy, done, illegal} <= '0;
      end else begin
         state <= ns;
         kind <= kn;
         fin <= fin_n;
         enc_input <= enc_n;
         reg_enable <= en_n;
         alu_sel <= alu_n;
         {read, inc_pc, gra, grb, r_in, r_out, con_in} <= {read_n, inc_n, gra_n, grb_n, rin_n, rout_n, conin_n};
         busy <= ns != IDLE || fin_n;
         done <= fin;
         illegal <= enter3 && kn == K_BAD;
      end
endmodule

// File: tb/tb_branch_step_sequencer.sv
// tb_branch_step_sequencer: directed timing checks for jal, jr, br taken/not taken, illegal opcode, clr abort and single-stepping
module tb_branch_step_sequencer;
   import ctrl_seq_pkg::*;
`ifdef SINGLE_STEP_EN
   localparam int D = 2;
   logic step_req = 1'b0;
`else
   localparam int D = 4;
`endif
   logic clock = 1'b0, clr = 1'b1, start = 1'b0, con_ff = 1'b0;
   logic [31:0] ir = 32'h0;
   logic [31:0] enc_input, reg_enable;
   logic [5:0] alu_sel;
   logic read, inc_pc, gra, grb, r_in, r_out, con_in, busy, done, illegal;
   logic [31:0] enc_h [64], en_h [64], alu_h [64], fl_h [64];
   logic [31:0] flags, any_done;
   int n_cmp = 0, n_bad = 0;
   assign flags = {22'h0, read, inc_pc, gra, grb, r_in, r_out, con_in, busy, done, illegal};
   always #5 clock = ~clock;
   branch_step_sequencer #(.STEP_DIV(D)) dut (
      .clock(clock), .clr(clr),
`ifdef SINGLE_STEP_EN
      .step_req(step_req),
`endif
      .start(start), .ir(ir), .con_ff(con_ff),
      .enc_input(enc_input), .reg_enable(reg_enable), .alu_sel(alu_sel),
      .read(read), .inc_pc(inc_pc), .gra(gra), .grb(grb), .r_in(r_in), .r_out(r_out),
      .con_in(con_in), .busy(busy), .done(done), .illegal(illegal)
   );
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic launch(input logic [4:0] op, input logic c, input int n, input int st_at, input int clr_at);
      ir = {op, 27'h15a5a5};
      con_ff = c;
      start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      for (int k = 0; k < n; k++) begin
         enc_h[k] = enc_input;
         en_h[k] = reg_enable;
         alu_h[k] = {26'h0, alu_sel};
         fl_h[k] = flags;
         start = k == st_at;
         clr = k == clr_at;
         @(negedge clock);
      end
      start = 1'b0;
      clr = 1'b0;
   endtask
   initial begin
      @(negedge clock);
      @(negedge clock);
      check("rst_enc", enc_input, 32'h0);
      check("rst_en", reg_enable, 32'h0);
      check("rst_flags", flags, 32'h0);
      clr = 1'b0;
`ifdef SINGLE_STEP_EN
      launch(OP_JAL, 1'b0, 12, -1, -1);
      check("ss_t0_enc", enc_h[0], 32'h0010_0000);
      check("ss_t0_cap", en_h[1], 32'h0080_0000);
      check("ss_stall_flags", fl_h[2], 32'h004);
      check("ss_stall_enc", enc_h[2], 32'h0);
      check("ss_held_flags", fl_h[11], 32'h004);
      check("ss_held_en", en_h[11], 32'h0);
      step_req = 1'b1;
      @(negedge clock);
      check("ss_t1_read", flags, 32'h204);
      step_req = 1'b0;
      @(negedge clock);
      check("ss_t1_cap", reg_enable, 32'h0040_0000);
      @(negedge clock);
      check("ss_restall", flags, 32'h004);
      step_req = 1'b1;
      @(negedge clock);
      check("ss_t2_enc", enc_input, 32'h0040_0000);
      step_req = 1'b0;
      clr = 1'b1;
      @(negedge clock);
      clr = 1'b0;
      check("ss_clr", flags, 32'h0);
`else
      launch(OP_JAL, 1'b0, 23, 8, -1);
      check("jal_t0_enc", enc_h[0], 32'h0010_0000);
      check("jal_t0_mid_en", en_h[2], 32'h0);
      check("jal_t0_cap", en_h[3], 32'h0080_0000);
      check("jal_t0_flags", fl_h[3], 32'h104);
      check("jal_t1_read", fl_h[5], 32'h204);
      check("jal_t1_cap", en_h[7], 32'h0040_0000);
      check("jal_t2_enc", enc_h[8], 32'h0040_0000);
      check("jal_t2_cap", en_h[11], 32'h0020_0000);
      check("jal_t3_ph0", fl_h[12], 32'h044);
      check("jal_t3_enc", enc_h[15], 32'h0010_0000);
      check("jal_t3_rin", fl_h[15], 32'h064);
      check("jal_t4_flags", fl_h[16], 32'h094);
      check("jal_t4_cap", en_h[19], 32'h0010_0000);
      check("jal_tail", fl_h[20], 32'h004);
      check("jal_done", fl_h[21], 32'h002);
      check("jal_after", fl_h[22], 32'h0);
      check("jal_busy_start_ignored", enc_h[22], 32'h0);
      launch(OP_JR, 1'b0, 23, 21, -1);
      check("jr_t3_flags", fl_h[12], 32'h004);
      check("jr_t3_enc", enc_h[12], 32'h0);
      check("jr_t4_flags", fl_h[16], 32'h094);
      check("jr_t4_cap", en_h[19], 32'h0010_0000);
      check("jr_done", fl_h[21], 32'h002);
      check("jr_restart_enc", enc_h[22], 32'h0010_0000);
      check("jr_restart_flags", fl_h[22], 32'h004);
      clr = 1'b1;
      @(negedge clock);
      clr = 1'b0;
      check("jr_clr", flags, 32'h0);
      launch(OP_BR, 1'b1, 31, -1, -1);
      check("brt_t3_flags", fl_h[12], 32'h094);
      check("brt_t3_conin", fl_h[15], 32'h09c);
      check("brt_t4_enc", enc_h[16], 32'h0010_0000);
      check("brt_t4_cap", en_h[19], 32'h0100_0000);
      check("brt_t5_enc", enc_h[20], 32'h0200_0000);
      check("brt_t5_alu", alu_h[20], 32'd3);
      check("brt_t5_cap", en_h[23], 32'h0008_0000);
      check("brt_t5_alu_cap", alu_h[23], 32'd3);
      check("brt_t6_enc", enc_h[24], 32'h0008_0000);
      check("brt_t6_alu", alu_h[24], 32'd0);
      check("brt_t6_cap", en_h[27], 32'h0010_0000);
      check("brt_tail", fl_h[28], 32'h004);
      check("brt_done", fl_h[29], 32'h002);
      launch(OP_BR, 1'b0, 31, -1, -1);
      check("brn_t6_enc", enc_h[27], 32'h0008_0000);
      check("brn_t6_cap", en_h[27], 32'h0);
      check("brn_tail", fl_h[28], 32'h004);
      check("brn_done", fl_h[29], 32'h002);
      launch(5'b00000, 1'b0, 26, -1, -1);
      check("ill_t2", fl_h[11], 32'h004);
      check("ill_pulse", fl_h[12], 32'h005);
      check("ill_enc", enc_h[12], 32'h0);
      check("ill_idle", fl_h[13], 32'h0);
      any_done = 32'h0;
      for (int k = 13; k < 26; k++) any_done |= {31'h0, fl_h[k][1]};
      check("ill_no_done", any_done, 32'h0);
      launch(OP_BR, 1'b1, 24, -1, 22);
      check("clr_t5_enc", enc_h[22], 32'h0200_0000);
      check("clr_t5_flags", fl_h[22], 32'h004);
      check("clr_enc", enc_h[23], 32'h0);
      check("clr_en", en_h[23], 32'h0);
      check("clr_alu", alu_h[23], 32'h0);
      check("clr_flags", fl_h[23], 32'h0);
      launch(OP_JAL, 1'b0, 4, -1, -1);
      check("restart_enc", enc_h[0], 32'h0010_0000);
      check("restart_flags", fl_h[0], 32'h004);
      check("restart_cap", en_h[3], 32'h0080_0000);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
